// File: rtl/pqc_modred_pkg.sv
// Shared constants, mode tag and Montgomery helpers for the Kyber/Dilithium reduction pipe.
package pqc_modred_pkg;

  localparam int KYBER_Q        = 3329;
  localparam int KYBER_QINV     = 62209;
  localparam int DILITHIUM_Q    = 8380417;
  localparam int DILITHIUM_QINV = 58728449;

  typedef enum logic {
    MODE_DIL = 1'b0,
    MODE_KYB = 1'b1
  } mode_e;

  localparam logic signed [15:0] KQ16 = 16'(KYBER_Q);
  localparam logic signed [31:0] DQ32 = 32'(DILITHIUM_Q);

  // Montgomery quotient; Kyber packs two 16-bit quotients, Dilithium one 32-bit.
  function automatic logic [31:0] mont_t(input mode_e m, input logic [63:0] a);
    logic [31:0] t;
    if (m == MODE_KYB) begin
      t[15:0]  = a[15:0]  * 16'(KYBER_QINV);
      t[31:16] = a[47:32] * 16'(KYBER_QINV);
    end else begin
      t = a[31:0] * 32'(DILITHIUM_QINV);
    end
    return t;
  endfunction

  function automatic logic [31:0] mont_r(input mode_e m, input logic [63:0] a,
                                         input logic [31:0] t);
    logic signed [47:0] dk;
    logic signed [65:0] dd;
    logic [31:0]        r;
    r = '0;
    if (m == MODE_KYB) begin
      for (int h = 0; h < 2; h++) begin
        dk = $signed({{16{a[32*h+31]}}, a[32*h +: 32]})
           - $signed({{32{t[16*h+15]}}, t[16*h +: 16]}) * $signed(48'(KYBER_Q));
        r[16*h +: 16] = dk[31:16];
      end
    end else begin
      dd = $signed({{2{a[63]}}, a})
         - $signed({{34{t[31]}}, t}) * $signed(66'(DILITHIUM_Q));
      r = dd[63:32];
    end
    return r;
  endfunction

  // Centred (-q,q) to canonical [0,q).
  function automatic logic [31:0] canon(input mode_e m, input logic [31:0] r);
    logic [31:0]        c;
    logic signed [15:0] x;
    logic signed [31:0] w;
    c = r;
    if (m == MODE_KYB) begin
      for (int i = 0; i < 2; i++) begin
        x = r[16*i +: 16];
        if (x[15])          x = x + KQ16;
        else if (x >= KQ16) x = x - KQ16;
        c[16*i +: 16] = x;
      end
    end else begin
      w = r;
      if (w[31])          w = w + DQ32;
      else if (w >= DQ32) w = w - DQ32;
      c = w;
    end
    return c;
  endfunction

endpackage

// File: rtl/bfu_modred_pipe_if.sv
// Beat handshake bundle for bfu_modred_pipe: source side, result side and flush.
interface bfu_modred_pipe_if #(
  parameter int LANES = 2
);
  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic                   selKD_i;
  logic [LANES-1:0][63:0] src_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [LANES-1:0][31:0] result_o;
  logic                   selKD_o;

  modport slave (
    input  flush_i, valid_i, selKD_i, src_i, ready_i,
    output ready_o, valid_o, result_o, selKD_o
  );

  modport master (
    output flush_i, valid_i, selKD_i, src_i, ready_i,
    input  ready_o, valid_o, result_o, selKD_o
  );
endinterface

// File: rtl/bfu_modred_pipe_lane.sv
// modred_lane: one 64-bit slot of Montgomery reduction, Kyber or Dilithium per beat.
module modred_lane
  import pqc_modred_pkg::*;
#(
  parameter int PIPE_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        en_i,
  input  mode_e       mode_i,
  input  logic [63:0] a_i,
  output logic [31:0] r_o
);

  if (PIPE_STAGES == 1) begin : g_one
    always_ff @(posedge clk_i)
      if (en_i) r_o <= mont_r(mode_i, a_i, mont_t(mode_i, a_i));
  end else begin : g_multi
    // Quotient is registered first; the wide subtract lands in the next stage.
    logic [63:0] a_q;
    logic [31:0] t_q;
    mode_e       m_q;
    logic [31:0] r_q [PIPE_STAGES-1];

    always_ff @(posedge clk_i) begin
      if (en_i) begin
        a_q    <= a_i;
        t_q    <= mont_t(mode_i, a_i);
        m_q    <= mode_i;
        r_q[0] <= mont_r(m_q, a_q, t_q);
        for (int s = 1; s < PIPE_STAGES - 1; s++) r_q[s] <= r_q[s-1];
      end
    end

    assign r_o = r_q[PIPE_STAGES-2];
  end

endmodule

// File: rtl/bfu_modred_pipe.sv
// Lane-parallel Montgomery reduction pipe with whole-pipe stall and flush.
// Define MODRED_CANON_EN to add a final stage mapping results into [0,q).
module bfu_modred_pipe
  import pqc_modred_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int PIPE_STAGES = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  bfu_modred_pipe_if.slave bus
);

`ifdef MODRED_CANON_EN
  localparam int STAGES = PIPE_STAGES + 1;
`else
  localparam int STAGES = PIPE_STAGES;
`endif

  logic                   advance;
  logic                   accept;
  logic                   out_vld;
  logic [STAGES:1]        vld_pipe;
  logic [STAGES:1]        kd_pipe;
  logic [LANES-1:0][31:0] lane_r;
  logic [LANES-1:0][31:0] out_r;

  assign out_vld     = vld_pipe[STAGES];
  assign advance     = ~(out_vld & ~bus.flush_i) | bus.ready_i;
  assign bus.ready_o = advance & ~bus.flush_i;
  assign accept      = bus.valid_i & bus.ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= accept;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Mode tag rides alongside the data and needs no reset.
  always_ff @(posedge clk_i) begin
    if (advance) begin
      kd_pipe[1] <= bus.selKD_i;
      for (int s = 2; s <= STAGES; s++) kd_pipe[s] <= kd_pipe[s-1];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    modred_lane #(.PIPE_STAGES(PIPE_STAGES)) u_lane (
      .clk_i  (clk_i),
      .en_i   (advance),
      .mode_i (mode_e'(bus.selKD_i)),
      .a_i    (bus.src_i[l]),
      .r_o    (lane_r[l])
    );
  end

`ifdef MODRED_CANON_EN
  logic [LANES-1:0][31:0] canon_q;
  always_ff @(posedge clk_i)
    if (advance)
      for (int l = 0; l < LANES; l++)
        canon_q[l] <= canon(mode_e'(kd_pipe[PIPE_STAGES]), lane_r[l]);
  assign out_r = canon_q;
`else
  assign out_r = lane_r;
`endif

  // Outputs read zero whenever the last stage is empty, so data regs stay reset-free.
  assign bus.valid_o  = out_vld & ~bus.flush_i;
  assign bus.result_o = out_vld ? out_r : '0;
  assign bus.selKD_o  = out_vld & kd_pipe[STAGES];

endmodule

// File: tb/tb_bfu_modred_pipe.sv
// Bench for bfu_modred_pipe: directed vectors plus an arithmetic reference model and scoreboard.
module tb_bfu_modred_pipe;
  import pqc_modred_pkg::*;

  localparam int LANES = 2;
  localparam int PS    = 2;
`ifdef MODRED_CANON_EN
  localparam int LAT   = PS + 1;
  localparam bit CANON = 1'b1;
`else
  localparam int LAT   = PS;
  localparam bit CANON = 1'b0;
`endif
  localparam longint P16 = 64'sd65536;
  localparam longint P32 = 64'sd4294967296;

  typedef logic [LANES-1:0][63:0] src_t;
  typedef logic [LANES-1:0][31:0] res_t;
  typedef struct packed { logic kd; res_t res; } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;
  exp_t sb[$];

  always #5 clk_i = ~clk_i;

  bfu_modred_pipe_if #(.LANES(LANES)) bus ();
  bfu_modred_pipe #(.LANES(LANES), .PIPE_STAGES(PS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: quotient modulo 2^k, then exact division of (a - t*q) by 2^k.
  function automatic logic [31:0] ref_slot(input logic kd, input logic [63:0] s);
    longint      a, t, r;
    logic [31:0] o;
    o = '0;
    if (kd) begin
      for (int h = 0; h < 2; h++) begin
        a = longint'($signed(s[32*h +: 32]));
        t = (a * 62209) % P16;
        if (t < 0) t += P16;
        if (t >= 32768) t -= P16;
        r = (a - t * 3329) / P16;
        if (CANON && r < 0) r += 3329;
        if (CANON && r >= 3329) r -= 3329;
        o[16*h +: 16] = r[15:0];
      end
    end else begin
      a = $signed(s);
      t = (a * 58728449) % P32;
      if (t < 0) t += P32;
      if (t >= 64'sd2147483648) t -= P32;
      r = (a - t * 8380417) / P32;
      if (CANON && r < 0) r += 8380417;
      if (CANON && r >= 8380417) r -= 8380417;
      o = r[31:0];
    end
    return o;
  endfunction

  function automatic src_t mk_src(input logic kd);
    src_t   s;
    int     lo, hi;
    longint d;
    for (int l = 0; l < LANES; l++) begin
      if (kd) begin
        lo = int'($urandom_range(0, 32'h07FF_FFFF)) - 32'sh0400_0000;
        hi = int'($urandom_range(0, 32'h07FF_FFFF)) - 32'sh0400_0000;
        s[l] = {hi, lo};
      end else begin
        d = longint'({$urandom, $urandom}) >>> 11;
        s[l] = d;
      end
    end
    return s;
  endfunction

  // Scoreboard: push on acceptance, compare every valid output cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: valid_o with no beat pending, result %h", bus.result_o);
      end else begin
        e = sb[0];
        chk("sb_result", 64'(bus.result_o), 64'(e.res));
        chk("sb_selKD", 64'(bus.selKD_o), 64'(e.kd));
        if (bus.ready_i) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
    if (rst_i || bus.flush_i) begin
      sb.delete();
    end else if (bus.valid_i && bus.ready_o) begin
      e.kd = bus.selKD_i;
      for (int l = 0; l < LANES; l++) e.res[l] = ref_slot(bus.selKD_i, bus.src_i[l]);
      sb.push_back(e);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_one(input string nm, input logic kd, input src_t s, input res_t e);
    int n;
    for (int l = 0; l < LANES; l++)
      chk({nm, "_model"}, 64'(ref_slot(kd, s[l])), 64'(e[l]));
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.selKD_i = kd;
    bus.src_i   = s;
    #1;
    chk({nm, "_ready_o"}, 64'(bus.ready_o), 64'(1));
    tick();
    bus.valid_i = 1'b0;
    n = 1;
    while (bus.valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    chk({nm, "_result"}, 64'(bus.result_o), 64'(e));
    chk({nm, "_selKD"}, 64'(bus.selKD_o), 64'(kd));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    src_t s;
    res_t e;
    int   k, guard, o0;
    logic acc;

    rst_i       = 1'b1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.selKD_i = 1'b0;
    bus.src_i   = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    #1;
    chk("rst_valid_o", 64'(bus.valid_o), 64'(0));
    chk("rst_result_o", 64'(bus.result_o), 64'(0));
    chk("rst_selKD_o", 64'(bus.selKD_o), 64'(0));
    chk("rst_ready_o", 64'(bus.ready_o), 64'(1));
    tick();

    // Kyber: 3329 -> 0, 5<<16 -> 5, -(5<<16) -> -5 (3324 canonical), 0 -> 0
    s[0] = {32'd3329, 32'(5 << 16)};
    s[1] = {32'd0, 32'(-(5 << 16))};
    e[0] = 32'h0000_0005;
    e[1] = CANON ? 32'h0000_0CFC : 32'h0000_FFFB;
    run_one("kyber", 1'b1, s, e);

    // Dilithium: 7<<32 -> 7, q -> 0
    s[0] = 64'h0000_0007_0000_0000;
    s[1] = 64'd8380417;
    e[0] = 32'd7;
    e[1] = 32'd0;
    run_one("dil", 1'b0, s, e);

    // Dilithium: -(7<<32) -> -7 (q-7 canonical), 2q -> 0
    s[0] = 64'hFFFF_FFF9_0000_0000;
    s[1] = 64'd16760834;
    e[0] = CANON ? 32'd8380410 : 32'hFFFF_FFF9;
    e[1] = 32'd0;
    run_one("dil_neg", 1'b0, s, e);

    // Alternating modes with random backpressure.
    o0 = n_out;
    k = 0;
    guard = 0;
    bus.valid_i = 1'b1;
    bus.selKD_i = 1'b1;
    bus.src_i   = mk_src(1'b1);
    while (k < 40 && guard < 2000) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      #1;
      acc = bus.valid_i & bus.ready_o;
      tick();
      guard++;
      if (acc) begin
        k++;
        bus.selKD_i = ~bus.selKD_i;
        bus.src_i   = mk_src(bus.selKD_i);
      end
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (LAT + 4) tick();
    chk("stream_accepted", 64'(k), 64'(40));
    chk("stream_count", 64'(n_out - o0), 64'(40));
    chk("stream_drained", 64'(sb.size()), 64'(0));

    // Flush with the pipe full; the beat offered alongside flush must be refused.
    for (int b = 0; b < LAT; b++) begin
      bus.valid_i = 1'b1;
      bus.selKD_i = b[0];
      bus.src_i   = mk_src(b[0]);
      tick();
    end
    bus.flush_i = 1'b1;
    bus.src_i   = mk_src(1'b1);
    #1;
    chk("flush_valid_o", 64'(bus.valid_o), 64'(0));
    chk("flush_ready_o", 64'(bus.ready_o), 64'(0));
    tick();
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("post_flush_valid_o", 64'(bus.valid_o), 64'(0));
    tick();
    s[0] = {32'd3329, 32'(5 << 16)};
    s[1] = {32'd0, 32'(-(5 << 16))};
    e[0] = 32'h0000_0005;
    e[1] = CANON ? 32'h0000_0CFC : 32'h0000_FFFB;
    run_one("after_flush", 1'b1, s, e);

    // Reset with a full, stalled pipe.
    bus.ready_i = 1'b0;
    for (int b = 0; b < LAT + 2; b++) begin
      bus.valid_i = 1'b1;
      bus.selKD_i = b[0];
      bus.src_i   = mk_src(b[0]);
      tick();
    end
    bus.valid_i = 1'b0;
    #1;
    chk("full_valid_o", 64'(bus.valid_o), 64'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_mid_valid_o", 64'(bus.valid_o), 64'(0));
    chk("rst_mid_result_o", 64'(bus.result_o), 64'(0));
    chk("rst_mid_selKD_o", 64'(bus.selKD_o), 64'(0));
    tick();
    #1;
    chk("rst_mid_ready_o", 64'(bus.ready_o), 64'(1));
    bus.ready_i = 1'b1;
    repeat (LAT + 3) tick();
    s[0] = 64'h0000_0007_0000_0000;
    s[1] = 64'd8380417;
    e[0] = 32'd7;
    e[1] = 32'd0;
    run_one("after_rst", 1'b0, s, e);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bfu_modred_pipe.md
BFU_MODRED_PIPE -- requirements
Module: bfu_modred_pipe

Interface
REQ-001 SHALL have parameter LANES, default 2: number of 64-bit source slots processed per beat (1..8).
REQ-002 SHALL have parameter PIPE_STAGES, default 2: register stages from accept to result (1..4).
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1: discard all in-flight beats.
REQ-006 SHALL have port valid_i, input, 1: source beat valid.
REQ-007 SHALL have port ready_o, output, 1: beat accepted when valid_i & ready_o.
REQ-008 SHALL have port selKD_i, input, 1: mode for the beat, Kyber (1) or Dilithium (0).
REQ-009 SHALL have port src_i, input, 64*LANES: per slot two signed 32-bit Kyber operands, or one signed 64-bit Dilithium operand.
REQ-010 SHALL have port valid_o, output, 1: result beat valid.
REQ-011 SHALL have port ready_i, input, 1: downstream accepts when valid_o & ready_i.
REQ-012 SHALL have port result_o, output, 32*LANES: per slot two signed 16-bit Kyber results, or one signed 32-bit Dilithium result.
REQ-013 SHALL have port selKD_o, output, 1: mode tag travelling with the result.

Function
REQ-014 Kyber lane: t = low16(a*QINV_K), QINV_K = 62209; r = (a - t*3329) >> 16, t taken signed 16-bit; low 32 bits of each slot -> result bits [15:0], high 32 bits -> [31:16].
REQ-015 Dilithium lane: t = low32(a*QINV_D), QINV_D = 58728449; r = (a - t*8380417) >> 32, t taken signed 32-bit.
REQ-016 Mode SHALL be captured per beat at acceptance and carried down the pipeline, so mixed-mode streams are legal back to back.
REQ-017 Latency SHALL be exactly PIPE_STAGES cycles from acceptance to valid_o when ready_i is held high; throughput one beat per cycle.
REQ-018 Pipeline SHALL stall as a whole: advance = ~valid_o | ready_i; ready_o = advance; no beat is dropped or duplicated.
REQ-019 While valid_o & ~ready_i, result_o and selKD_o SHALL hold stable.
REQ-020 flush_i SHALL clear every stage valid bit on the next edge; a beat offered in the flush cycle SHALL NOT be accepted (ready_o = 0 while flush_i).
REQ-021 valid_o SHALL be masked combinationally by ~flush_i.
REQ-022 Data registers SHALL load only on advance; valid bits are the sole state requiring reset.

Reset
REQ-023 On rst_i: all stage valid bits = 0, valid_o = 0, result_o = 0, selKD_o = 0; ready_o = 1 from the first cycle after reset.
REQ-024 Reset mid-stream SHALL discard all in-flight beats with no later output.

Configuration
REQ-025 Macro MODRED_CANON_EN: when defined, add one correction stage (latency PIPE_STAGES+1) mapping each result to canonical [0,q) by conditional +q / -q.
REQ-026 Without MODRED_CANON_EN: results are centred signed in (-q,q), latency PIPE_STAGES.

Structure
REQ-027 Package pqc_modred_pkg SHALL hold KYBER_Q, KYBER_QINV, DILITHIUM_Q, DILITHIUM_QINV, and a mode enum typedef.
REQ-028 Sub-module modred_lane SHALL implement one 64-bit slot in both modes, pipelined internally, with an enable for the stall; instantiated LANES times.

Verification
REQ-029 Reset, then Kyber slot src = {32'd3329, 32'(5<<16)} -> result {16'd0, 16'd5} after PIPE_STAGES cycles.
REQ-030 Dilithium slot src = 64'(7<<32) -> result 32'd7; src = 64'd8380417 -> 32'd0.
REQ-031 Kyber src low = -(5<<16) -> -5 (16'hFFFB) without MODRED_CANON_EN; 16'd3324 with it.
REQ-032 Alternate Kyber/Dilithium beats every cycle while ready_i toggles randomly -> results in order, selKD_o matches each beat, none lost or duplicated.
REQ-033 flush_i with PIPE_STAGES beats in flight -> valid_o low that cycle, no flushed beat ever appears; the next accepted beat emerges with normal latency.
REQ-034 rst_i asserted with a full pipeline and ready_i = 0 -> valid_o = 0 next cycle; ready_o = 1 the cycle after rst_i deasserts.
